// File: rtl/riscv_cpu_pkg.sv
// Shared fetch front-end types and constants.
package riscv_cpu_pkg;

    typedef enum logic [1:0] {
        PC_NEXT   = 2'b00,
        PC_JUMP   = 2'b01,
        PC_BRANCH = 2'b10,
        PC_BOOT   = 2'b11
    } pc_mux_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// Prefetch FIFO holding {instr, pc} words for decode.
module fetch_fifo #(
    parameter int          DEPTH   = 2,
    parameter int          WIDTH   = 64,
    parameter logic [63:0] RST_VAL = '0,
    localparam int         AW      = $clog2(DEPTH),
    localparam int         CW      = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rptr_q];

    always_comb begin
        push_ok = push_i && (!full_o || pop_i);
        pop_ok  = pop_i && !empty_o;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        // Flush wins over any same-cycle push or pop.
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wptr_q] = wdata_i;
                wptr_d        = wptr_q + AW'(1);
            end
            if (pop_ok) begin
                rptr_d = rptr_q + AW'(1);
            end
            cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RST_VAL[WIDTH-1:0];
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, single-outstanding memory port,
// prefetch FIFO and redirect handling toward decode.
module if_stage
    import riscv_cpu_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic [1:0]  pc_mux_i,
    input  logic [31:0] jump_addr_i,
    input  logic [31:0] branch_addr_i,
    input  logic        id_ready_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] pc_id_o
);

    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [31:0] BOOT_PC = BOOT_ADDR & 32'hFFFF_FFFC;

    fetch_state_e  state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          discard_q, discard_d;
    logic [31:0]   target;
    logic          redirect, push, pop;
    logic          fifo_empty, fifo_full;
    logic [CW-1:0] fifo_count, cnt_after;
    logic [63:0]   head;

    assign redirect      = (pc_mux_i != PC_NEXT);
    assign instr_valid_o = !fifo_empty;
    assign pop           = instr_valid_o && id_ready_i && !redirect;
    assign push          = (state_q == WAIT) && instr_rvalid_i
                           && !discard_q && !redirect;
    assign cnt_after     = redirect ? '0
                         : fifo_count + CW'(push) - CW'(pop);
    assign instr_req_o   = (state_q == REQ);
    assign instr_addr_o  = addr_q;
    assign {instr_rdata_o, pc_id_o} = head;

    always_comb begin
        target = BOOT_PC;
        unique case (pc_mux_e'(pc_mux_i))
            PC_JUMP:   target = jump_addr_i & 32'hFFFF_FFFC;
            PC_BRANCH: target = branch_addr_i & 32'hFFFF_FFFC;
            default:   target = BOOT_PC;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        if (redirect) begin
            fetch_pc_d = target;
        end
        unique case (state_q)
            IDLE: begin
                if (!redirect && !fifo_full) begin
                    state_d = REQ;
                    addr_d  = fetch_pc_q;
                end
            end
            REQ: begin
                // The granted word belongs to the old path once redirected.
                if (redirect) begin
                    discard_d = 1'b1;
                end
                if (instr_gnt_i) begin
                    state_d = WAIT;
                    if (!redirect && !discard_q) begin
                        fetch_pc_d = addr_q + 32'd4;
                    end
                end
            end
            WAIT: begin
                if (redirect) begin
                    discard_d = 1'b1;
                end
                if (instr_rvalid_i) begin
                    discard_d = 1'b0;
                    if (cnt_after < DEPTH_C) begin
                        state_d = REQ;
                        addr_d  = fetch_pc_d;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_q     <= BOOT_PC;
            fetch_pc_q <= BOOT_PC;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .WIDTH   (64),
        .RST_VAL ({NOP, 32'h0})
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (redirect),
        .push_i  (push),
        .wdata_i ({instr_rdata_i, addr_q}),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus random traffic
// checked against a program-order fetch model.
module tb_if_stage;

    localparam logic [31:0] BOOT = 32'h0000_0000;
    localparam logic [31:0] NOPV = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic [1:0]  pc_mux_i;
    logic [31:0] jump_addr_i;
    logic [31:0] branch_addr_i;
    logic        id_ready_i;
    logic        instr_valid_o;
    logic [31:0] instr_rdata_o;
    logic [31:0] pc_id_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_dly = 0;
    int          lat_max = 1;
    logic        stray = 1'b0;
    logic [31:0] exp_pc = BOOT;
    int          n_pops = 0;
    int          first = -1;
    int          n0;
    logic [31:0] held;
    logic [31:0] req_log[$];

    logic        p_valid = 0, p_ready = 0, p_redir = 0;
    logic        p_req = 0, p_gnt = 0;
    logic [31:0] p_addr = '0, p_pc = '0, p_rdata = '0;

    always #5 clk_i = ~clk_i;

    if_stage #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(2)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .pc_mux_i       (pc_mux_i),
        .jump_addr_i    (jump_addr_i),
        .branch_addr_i  (branch_addr_i),
        .id_ready_i     (id_ready_i),
        .instr_valid_o  (instr_valid_o),
        .instr_rdata_o  (instr_rdata_o),
        .pc_id_o        (pc_id_o)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    function automatic logic [31:0] tgt(input logic [1:0] m);
        case (m)
            2'b01:   return jump_addr_i & 32'hFFFF_FFFC;
            2'b10:   return branch_addr_i & 32'hFFFF_FFFC;
            default: return BOOT;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: observe at negedge, then drive memory after posedge.
    task automatic tick();
        logic redir;
        @(negedge clk_i);
        redir = (pc_mux_i != 2'b00);
        if (!rst_ni) begin
            exp_pc  = BOOT;
            pend    = 1'b0;
            p_valid = 1'b0;
            p_req   = 1'b0;
        end else begin
            if (p_req && !p_gnt) begin
                chk("addr_hold_req", {31'b0, instr_req_o}, 32'd1);
                chk("addr_hold", instr_addr_o, p_addr);
            end
            if (p_valid && !p_ready && !p_redir) begin
                chk("out_hold_valid", {31'b0, instr_valid_o}, 32'd1);
                chk("out_hold_pc", pc_id_o, p_pc);
                chk("out_hold_data", instr_rdata_o, p_rdata);
            end
            if (instr_req_o) begin
                chk("one_outstanding",
                    {31'b0, pend | instr_rvalid_i}, 32'd0);
            end
            if (instr_req_o && instr_gnt_i) begin
                chk("addr_align", {30'b0, instr_addr_o[1:0]}, 32'd0);
                req_log.push_back(instr_addr_o);
                pend      = 1'b1;
                pend_addr = instr_addr_o;
                pend_dly  = $urandom_range(lat_max, 1);
            end
            if (redir) begin
                exp_pc = tgt(pc_mux_i);
            end else if (instr_valid_o && id_ready_i) begin
                chk("pop_pc", pc_id_o, exp_pc);
                chk("pop_data", instr_rdata_o, memf(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_pops++;
            end
            p_valid = instr_valid_o;
            p_ready = id_ready_i;
            p_redir = redir;
            p_req   = instr_req_o;
            p_gnt   = instr_gnt_i;
            p_addr  = instr_addr_o;
            p_pc    = pc_id_o;
            p_rdata = instr_rdata_o;
        end
        @(posedge clk_i);
        #1;
        instr_rvalid_i = 1'b0;
        if (stray) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = 32'hDEAD_BEEF;
            stray          = 1'b0;
        end else if (pend) begin
            if (pend_dly <= 1) begin
                instr_rvalid_i = 1'b1;
                instr_rdata_i  = memf(pend_addr);
                pend           = 1'b0;
            end else begin
                pend_dly--;
            end
        end
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] pc);
        int k;
        k = 0;
        while (!instr_valid_o && k < 40) begin
            tick();
            k++;
        end
        chk({tag, "_valid"}, {31'b0, instr_valid_o}, 32'd1);
        chk({tag, "_pc"}, pc_id_o, pc);
    endtask

    task automatic wait_grant(input string tag, input int base,
                              input logic [31:0] addr);
        int k;
        k = 0;
        while (req_log.size() <= base && k < 40) begin
            tick();
            k++;
        end
        chk({tag, "_granted"}, {31'b0, req_log.size() > base}, 32'd1);
        if (req_log.size() > base) begin
            chk({tag, "_addr"}, req_log[base], addr);
        end
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_req"}, {31'b0, instr_req_o}, 32'd0);
        chk({tag, "_addr"}, instr_addr_o, BOOT);
        chk({tag, "_valid"}, {31'b0, instr_valid_o}, 32'd0);
        chk({tag, "_rdata"}, instr_rdata_o, NOPV);
        chk({tag, "_pc"}, pc_id_o, 32'd0);
    endtask

    initial begin
        rst_ni         = 1'b0;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
        pc_mux_i       = 2'b00;
        jump_addr_i    = '0;
        branch_addr_i  = '0;
        id_ready_i     = 1'b0;
        repeat (3) tick();
        reset_outputs("reset");

        // Sequential fetch from boot, gnt high, 1-cycle latency.
        instr_gnt_i = 1'b1;
        id_ready_i  = 1'b1;
        lat_max     = 1;
        req_log.delete();
        rst_ni = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (instr_valid_o && first < 0) begin
                first = i;
                chk("first_pc", pc_id_o, BOOT);
            end
        end
        chk("first_valid_lat", 32'(first), 32'd3);
        chk("seq_count", {31'b0, req_log.size() >= 3}, 32'd1);
        if (req_log.size() >= 3) begin
            chk("seq_addr0", req_log[0], 32'h0);
            chk("seq_addr1", req_log[1], 32'h4);
            chk("seq_addr2", req_log[2], 32'h8);
        end

        // Decode stall: FIFO fills, requests stop, head holds.
        id_ready_i = 1'b0;
        repeat (10) tick();
        chk("stall_req", {31'b0, instr_req_o}, 32'd0);
        chk("stall_valid", {31'b0, instr_valid_o}, 32'd1);
        chk("stall_idle", {31'b0, pend | instr_rvalid_i}, 32'd0);
        id_ready_i = 1'b1;
        tick();
        chk("stall_second", {31'b0, instr_valid_o}, 32'd1);
        repeat (4) tick();

        // Jump while a response is outstanding.
        lat_max = 3;
        n0 = 0;
        while (!pend && n0 < 40) begin
            tick();
            n0++;
        end
        chk("jump_in_wait", {31'b0, pend}, 32'd1);
        n0          = req_log.size();
        pc_mux_i    = 2'b01;
        jump_addr_i = 32'h0000_0100;
        tick();
        pc_mux_i = 2'b00;
        chk("jump_flush", {31'b0, instr_valid_o}, 32'd0);
        wait_grant("jump_req", n0, 32'h100);
        wait_valid("jump_first", 32'h100);

        // Branch while the request is stalled without gnt.
        instr_gnt_i = 1'b0;
        n0 = 0;
        while (!instr_req_o && n0 < 40) begin
            tick();
            n0++;
        end
        chk("branch_req_seen", {31'b0, instr_req_o}, 32'd1);
        held          = instr_addr_o;
        pc_mux_i      = 2'b10;
        branch_addr_i = 32'h0000_0200;
        tick();
        pc_mux_i = 2'b00;
        repeat (2) tick();
        chk("branch_hold_addr", instr_addr_o, held);
        n0          = req_log.size();
        instr_gnt_i = 1'b1;
        wait_grant("branch_old", n0, held);
        wait_grant("branch_new", n0 + 1, 32'h200);
        wait_valid("branch_first", 32'h200);

        // Redirect coinciding with rvalid and a pop.
        id_ready_i = 1'b0;
        lat_max    = 1;
        n0 = 0;
        while (!(instr_rvalid_i && instr_valid_o) && n0 < 40) begin
            tick();
            n0++;
        end
        chk("coinc_found",
            {31'b0, instr_rvalid_i && instr_valid_o}, 32'd1);
        id_ready_i  = 1'b1;
        pc_mux_i    = 2'b01;
        jump_addr_i = 32'h0000_0300;
        tick();
        pc_mux_i = 2'b00;
        chk("coinc_empty", {31'b0, instr_valid_o}, 32'd0);
        wait_valid("coinc_first", 32'h300);

        // Reset in WAIT, then a stray rvalid.
        lat_max = 3;
        n0 = 0;
        while (!pend && n0 < 40) begin
            tick();
            n0++;
        end
        rst_ni = 1'b0;
        #1;
        reset_outputs("midrst");
        repeat (2) tick();
        req_log.delete();
        stray = 1'b1;
        tick();
        rst_ni = 1'b1;
        tick();
        wait_grant("reboot", 0, BOOT);
        wait_valid("reboot_first", BOOT);
        chk("reboot_data", instr_rdata_o, memf(BOOT));

        // Random traffic against the program-order model.
        n_pops = 0;
        for (int i = 0; i < 800; i++) begin
            instr_gnt_i = $urandom_range(1, 0) == 1;
            id_ready_i  = $urandom_range(9, 0) < 7;
            if ($urandom_range(31, 0) == 0) begin
                pc_mux_i      = 2'($urandom_range(3, 1));
                jump_addr_i   = $urandom & 32'h0000_FFFF;
                branch_addr_i = $urandom & 32'h0000_FFFF;
            end else begin
                pc_mux_i = 2'b00;
            end
            tick();
        end
        pc_mux_i    = 2'b00;
        instr_gnt_i = 1'b1;
        id_ready_i  = 1'b1;
        repeat (20) tick();
        chk("random_progress", {31'b0, n_pops > 50}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
